// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   MEM-stage data-bus access controller. Takes one load or store from the
//   EXE/MEM register, issues it on a req/addr_ok/data_ok bus, stalls the
//   pipeline while it is in flight and returns an aligned, extended load result.
//
//   Bus handshake: data_req is held high with stable data_addr/wr/size/wdata/
//   wstrb until the cycle data_addr_ok=1 is seen (address phase done). The
//   response phase ends on the first later (or same-cycle) data_data_ok=1.
//   At most one transaction is outstanding; data_data_ok outside an
//   in-flight transaction is ignored.
//
// Ports
//   clk, rst               clock, asynchronous active-low reset
//   mem_valid .. mem_flush MEM-stage instruction info (EXE/MEM register)
//   pipe_advance           MEM/WB accepts this cycle
//   mem_stall              hold the pipeline
//   load_data, load_valid  completed load result
//   addr_err               misaligned access (combinational)
//   data_*                 data bus request/response
//   state_dbg              FSM state: 0 IDLE, 1 REQ, 2 WAIT, 3 DONE
//   cancel_dbg             in-flight transaction was flushed
//
// Only DATA_W = 32 is supported (byte-lane logic assumes four lanes).

module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        mem_load_type,
  input  logic [1:0]        mem_store_type,
  input  logic              mem_except,
  input  logic              mem_flush,
  input  logic              pipe_advance,
  output logic              mem_stall,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              addr_err,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [1:0]        state_dbg,
  output logic              cancel_dbg
);

  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;
  localparam logic [2:0] LT_LW  = 3'd5;
  localparam logic [1:0] ST_SB  = 2'd1;
  localparam logic [1:0] ST_SH  = 2'd2;
  localparam logic [1:0] ST_SW  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic        cancel;
  logic [2:0]  ld_type_q;
  logic        access_req;
  logic        resp_done;
  logic        resp_cancel;
  logic [1:0]  req_size;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [DATA_W-1:0] ld_result;

  // Misalignment check on the raw pipeline inputs.
  always_comb begin
    addr_err = 1'b0;
    if ((mem_load_type == LT_LH || mem_load_type == LT_LHU || mem_store_type == ST_SH)
        && mem_addr[0])
      addr_err = 1'b1;
    if ((mem_load_type == LT_LW || mem_store_type == ST_SW) && mem_addr[1:0] != 2'b00)
      addr_err = 1'b1;
  end

  assign access_req = mem_valid && (mem_load_type != 3'd0 || mem_store_type != 2'd0)
                      && !mem_except && !mem_flush && !addr_err;

  // Request fields; a store type takes precedence over a load type.
  always_comb begin
    req_size  = 2'd0;
    req_wdata = '0;
    req_wstrb = 4'b0000;
    case (mem_store_type)
      ST_SB: begin
        req_size  = 2'd0;
        req_wdata = {4{mem_wdata[7:0]}};
        req_wstrb = 4'b0001 << mem_addr[1:0];
      end
      ST_SH: begin
        req_size  = 2'd1;
        req_wdata = {2{mem_wdata[15:0]}};
        req_wstrb = mem_addr[1] ? 4'b1100 : 4'b0011;
      end
      ST_SW: begin
        req_size  = 2'd2;
        req_wdata = mem_wdata;
        req_wstrb = 4'b1111;
      end
      default: begin
        case (mem_load_type)
          LT_LH, LT_LHU: req_size = 2'd1;
          LT_LW:         req_size = 2'd2;
          default:       req_size = 2'd0;
        endcase
      end
    endcase
  end

  // Load lane selection uses the registered address, which is stable
  // for the whole transaction.
  always_comb begin
    case (data_addr[1:0])
      2'd0:    ld_byte = data_rdata[7:0];
      2'd1:    ld_byte = data_rdata[15:8];
      2'd2:    ld_byte = data_rdata[23:16];
      default: ld_byte = data_rdata[31:24];
    endcase
    ld_half = data_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (ld_type_q)
      LT_LB:   ld_result = {{24{ld_byte[7]}}, ld_byte};
      LT_LBU:  ld_result = {24'd0, ld_byte};
      LT_LH:   ld_result = {{16{ld_half[15]}}, ld_half};
      LT_LHU:  ld_result = {16'd0, ld_half};
      default: ld_result = data_rdata;
    endcase
  end

  assign resp_done   = (state == REQ && data_addr_ok && data_data_ok)
                    || (state == WAIT && data_data_ok);
  // A flush arriving in the very cycle of the response still cancels it.
  assign resp_cancel = cancel || mem_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cancel     <= 1'b0;
      ld_type_q  <= 3'd0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= '0;
      data_wdata <= '0;
      data_wstrb <= 4'b0000;
      load_data  <= '0;
      load_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access_req) begin
            data_addr  <= mem_addr;
            data_wr    <= (mem_store_type != 2'd0);
            data_size  <= req_size;
            data_wdata <= req_wdata;
            data_wstrb <= req_wstrb;
            ld_type_q  <= (mem_store_type != 2'd0) ? 3'd0 : mem_load_type;
            cancel     <= 1'b0;
            state      <= REQ;
          end
        end
        REQ: begin
          // The request is never withdrawn; a flush only marks it cancelled.
          if (mem_flush) cancel <= 1'b1;
          if (data_addr_ok && !data_data_ok) state <= WAIT;
        end
        WAIT: begin
          if (mem_flush) cancel <= 1'b1;
        end
        DONE: begin
          if (pipe_advance || mem_flush) begin
            state      <= IDLE;
            load_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (resp_done) begin
        if (resp_cancel) begin
          state      <= IDLE;
          cancel     <= 1'b0;
          load_valid <= 1'b0;
        end else begin
          state      <= DONE;
          load_valid <= (ld_type_q != 3'd0);
          if (ld_type_q != 3'd0) load_data <= ld_result;
        end
      end
    end
  end

  assign data_req   = (state == REQ);
  assign mem_stall  = (state == REQ) || (state == WAIT) || (state == IDLE && access_req);
  assign state_dbg  = state;
  assign cancel_dbg = cancel;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, 32, data bus address width in bits.
REQ-002 Parameter DATA_W, 32, data bus data width in bits; only 32 is supported.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 Pipeline-side inputs, all fed from the EXE/MEM register outputs:
- mem_valid  in  1  MEM-stage instruction is valid.
- mem_addr  in  32  effective address (ALU output).
- mem_wdata  in  32  store source (OutB).
- mem_load_type  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW.
- mem_store_type  in  2  0 none, 1 SB, 2 SH, 3 SW.
- mem_except  in  1  an exception is already pending; suppresses the access.
- mem_flush  in  1  flush the MEM stage.
- pipe_advance  in  1  MEM/WB accepts this cycle.
REQ-006 Pipeline-side outputs:
- mem_stall  out  1  hold the pipeline.
- load_data  out  32  aligned and extended load result.
- load_valid  out  1  load_data holds a completed load.
- addr_err  out  1  misaligned access detected.
REQ-007 Bus outputs:
- data_req  out  1  request.
- data_wr  out  1  1 = store.
- data_size  out  2  0 byte, 1 half, 2 word.
- data_addr  out  32  request address.
- data_wdata  out  32  store data.
- data_wstrb  out  4  byte enables.
REQ-008 Bus inputs:
- data_addr_ok  in  1  address accepted.
- data_data_ok  in  1  response complete.
- data_rdata  in  32  read data.

Function
REQ-009 An access is required when mem_valid=1, (load_type!=0 or store_type!=0), mem_except=0, mem_flush=0 and addr_err=0.
REQ-010 addr_err is combinational and SHALL be 1 when:
- LH, LHU or SH with addr[0]=1; or
- LW or SW with addr[1:0]!=0.
addr_err is 0 in every other case. A misaligned access issues no request and does not stall.
REQ-011 FSM states are IDLE, REQ, WAIT and DONE.
REQ-012 IDLE: when an access is required, register addr, wr, size, wdata and wstrb, then go to REQ; mem_stall=1 combinationally in that cycle.
REQ-013 REQ: data_req=1 with stable registered fields until data_addr_ok=1. On addr_ok with data_ok=1 in the same cycle, go to DONE; on addr_ok alone, go to WAIT.
REQ-014 WAIT: data_req=0. On data_data_ok=1, go to DONE and capture the processed load result.
REQ-015 DONE: mem_stall=0; load_valid=1 for loads, 0 for stores. On pipe_advance=1 or mem_flush=1, go to IDLE and clear load_valid.
REQ-016 mem_stall SHALL be 1 in REQ and WAIT, and 0 in DONE and in IDLE with no required access.
REQ-017 Store data and strobes:
- SB: wdata = byte replicated x4, wstrb = 1 << addr[1:0].
- SH: wdata = half replicated x2, wstrb = 0011 if addr[1]=0, else 1100.
- SW: wdata = source, wstrb = 1111.
REQ-018 Load result: select the byte lane addr[1:0] (byte) or the half lane addr[1] (half). LB/LH sign-extend, LBU/LHU zero-extend, LW passes rdata through.
REQ-019 data_addr is the full mem_addr; the low bits are not masked.
REQ-020 Flush in REQ or WAIT: the transaction SHALL NOT be abandoned (req stays high until addr_ok). Set the cancel flag; on data_ok go to IDLE instead of DONE, with load_valid=0. mem_stall stays 1 until data_ok.
REQ-021 Only one outstanding transaction is allowed; no new request is issued before data_ok of the current one.
REQ-022 data_data_ok in IDLE or DONE SHALL be ignored.

Reset
REQ-023 While rst=0, outputs SHALL be: state IDLE, data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0, data_wstrb=0, load_data=0, load_valid=0, cancel=0.
REQ-024 Reset mid-transaction SHALL drop data_req immediately; a response arriving after reset is ignored.

Verification
REQ-025 LB, addr=0x1003, rdata=0x80FF_1234 -> data_size=0, load_data=0xFFFF_FF80, load_valid=1 in DONE.
REQ-026 SH, addr=0x2002, wdata=0x0000_ABCD -> data_wr=1, data_wdata=0xABCD_ABCD, data_wstrb=1100, stall released in DONE.
REQ-027 LW, addr=0x3001 -> addr_err=1, data_req stays 0, mem_stall=0.
REQ-028 LW; addr_ok held 0 for 3 cycles, then addr_ok and data_ok together with rdata=0x1234_5678 -> data_req high for 4 cycles, state REQ->DONE, load_data=0x1234_5678.
REQ-029 Flush asserted in WAIT, then data_ok -> state IDLE, load_valid=0, no further request.
REQ-030 rst=0 asserted in REQ -> data_req=0 in the same cycle, all outputs zero; a later data_ok is ignored.
